samp_phase_ctrl: RTL

- Digital sequencer that generates the control phases for the analog sampling switch (`vin`→`vout`): the true/complement switch clocks `samp`/`samp_b` and the conversion-enable handed to the SAR logic.
- Guarantees both of the following:
  - A programmable track window.
  - Guard (dead) intervals between switch-open and conversion, in both directions, so the switch is never closed while the array is converting.
- Sits in the ADC digital core between the frame controller (`start`/`busy`) and the sampswitch/SAR blocks.

---
 rtl/samp_phase_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/samp_phase_ctrl.sv
// Sampling-switch phase sequencer: track window, guard intervals and SAR
// conversion enable, with single-frame and continuous operation.
module samp_phase_ctrl #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEAD  = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             cont,
  input  logic [CNT_W-1:0] samp_len,
  input  logic             conv_done,
  output logic             samp,
  output logic             samp_b,
  output logic             conv_en,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRACK      = 3'd1,
    GUARD_PRE  = 3'd2,
    CONV       = 3'd3,
    GUARD_POST = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] len_lat;
  logic             cnt_last;
  logic             samp_nxt, conv_en_nxt, busy_nxt, frame_done_nxt;

  // A zero-length track request still closes the switch for one cycle.
  assign len_lat  = (samp_len == '0) ? ONE_CNT : samp_len;
  assign cnt_last = (cnt <= ONE_CNT);

  // Next state, down-counter and the registered-output inputs.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          state_nxt = TRACK;
          cnt_nxt   = len_lat;
        end
      end
      TRACK: begin
        if (cnt_last) begin
          state_nxt = GUARD_PRE;
          cnt_nxt   = DEAD_CNT;
        end else begin
          cnt_nxt = cnt - ONE_CNT;
        end
      end
      GUARD_PRE: begin
        if (cnt_last) begin
          state_nxt = CONV;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - ONE_CNT;
        end
      end
      CONV: begin
        if (conv_done) begin
          state_nxt = GUARD_POST;
          cnt_nxt   = DEAD_CNT;
        end
      end
      GUARD_POST: begin
        if (cnt_last) begin
          frame_done_nxt = 1'b1;
          if (cont) begin
            state_nxt = TRACK;
            cnt_nxt   = len_lat;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - ONE_CNT;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs follow the state being entered so they change on the same edge.
    samp_nxt    = (state_nxt == TRACK);
    conv_en_nxt = (state_nxt == CONV);
    busy_nxt    = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      cnt        <= '0;
      samp       <= 1'b0;
      samp_b     <= 1'b1;
      conv_en    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      samp       <= samp_nxt;
      samp_b     <= ~samp_nxt;
      conv_en    <= conv_en_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule
